// File: rtl/spmm_tile_sequencer.sv
// Control FSM for the SpMM engine: sequences rhs load, PE compute window
// and output drain, tracking weight- and output-stationary state.
module spmm_tile_sequencer #(
    parameter int N              = 16,
    parameter int COMPUTE_CYCLES = 22,
    localparam int LGN = $clog2(N),
    localparam int BW  = LGN - 2,
    localparam int CW  = $clog2(COMPUTE_CYCLES + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           rhs_start,
    input  logic           lhs_start,
    input  logic           lhs_ws,
    input  logic           lhs_os,
    input  logic           out_start,
    output logic           rhs_ready,
    output logic           lhs_ready_ns,
    output logic           lhs_ready_ws,
    output logic           lhs_ready_os,
    output logic           lhs_ready_wos,
    output logic           out_ready,
    output logic           rhs_wr_en,
    output logic [LGN-1:0] rhs_row_base,
    output logic           pe_start,
    output logic           acc_en,
    output logic           out_rd_en,
    output logic [LGN-1:0] out_row_base,
    output logic           out_last,
    output logic           lhs_reject,
    output logic           busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    localparam logic [BW-1:0] LAST_BEAT = BW'(N / 4 - 1);
    localparam logic [CW-1:0] CMAX      = CW'(COMPUTE_CYCLES);

    state_t        state_q, state_d;
    logic          rhs_keep_q, rhs_keep_d;
    logic          acc_pending_q, acc_pending_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ws_q, ws_d;
    logic          os_q, os_d;
    logic          reject_q, reject_d;

    logic idle_armed, armed;
    logic out_acc, rhs_acc, lhs_acc, lhs_ok;

    assign idle_armed    = (state_q == S_IDLE) || (state_q == S_ARMED);
    assign armed         = (state_q == S_ARMED);
    assign rhs_ready     = idle_armed;
    assign out_ready     = idle_armed & acc_pending_q;
    assign lhs_ready_ns  = armed & ~acc_pending_q;
    assign lhs_ready_ws  = armed & ~acc_pending_q;
    assign lhs_ready_os  = armed & acc_pending_q;
    assign lhs_ready_wos = armed & acc_pending_q;
    assign busy          = ~idle_armed;
    assign lhs_reject    = reject_q;

    // An lhs op is only legal when its os flavour matches the pending result.
    assign lhs_ok  = lhs_ws ? (lhs_os ? lhs_ready_wos : lhs_ready_ws)
                            : (lhs_os ? lhs_ready_os : lhs_ready_ns);
    assign out_acc = out_start & out_ready;
    assign rhs_acc = rhs_start & rhs_ready & ~out_acc;
    assign lhs_acc = lhs_start & lhs_ok & ~out_acc & ~rhs_acc;

    always_comb begin
        state_d       = state_q;
        rhs_keep_d    = rhs_keep_q;
        acc_pending_d = acc_pending_q;
        beat_d        = beat_q;
        cnt_d         = cnt_q;
        ws_d          = ws_q;
        os_d          = os_q;
        reject_d      = lhs_start & ~lhs_acc;
        rhs_wr_en     = 1'b0;
        pe_start      = 1'b0;
        acc_en        = 1'b0;
        out_rd_en     = 1'b0;
        out_last      = 1'b0;
        unique case (state_q)
            S_IDLE, S_ARMED: begin
                if (out_acc) begin
                    state_d = S_DRAIN;
                    beat_d  = '0;
                end else if (rhs_acc) begin
                    rhs_wr_en = 1'b1;
                    state_d   = S_LOAD;
                    beat_d    = BW'(1);
                end else if (lhs_acc) begin
                    state_d = S_COMPUTE;
                    cnt_d   = CW'(1);
                    ws_d    = lhs_ws;
                    os_d    = lhs_os;
                end
            end
            S_LOAD: begin
                rhs_wr_en = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    state_d    = S_ARMED;
                    rhs_keep_d = 1'b1;
                    beat_d     = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            S_COMPUTE: begin
                pe_start = (cnt_q == CW'(1));
                acc_en   = os_q;
                if (cnt_q == CMAX) begin
                    state_d       = ws_q ? S_ARMED : S_IDLE;
                    rhs_keep_d    = ws_q;
                    acc_pending_d = 1'b1;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                out_rd_en = 1'b1;
                out_last  = (beat_q == LAST_BEAT);
                if (beat_q == LAST_BEAT) begin
                    state_d       = rhs_keep_q ? S_ARMED : S_IDLE;
                    acc_pending_d = 1'b0;
                    beat_d        = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rhs_row_base = rhs_wr_en ? {beat_q, 2'b00} : '0;
    assign out_row_base = out_rd_en ? {beat_q, 2'b00} : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rhs_keep_q    <= 1'b0;
            acc_pending_q <= 1'b0;
            beat_q        <= '0;
            cnt_q         <= '0;
            ws_q          <= 1'b0;
            os_q          <= 1'b0;
            reject_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rhs_keep_q    <= rhs_keep_d;
            acc_pending_q <= acc_pending_d;
            beat_q        <= beat_d;
            cnt_q         <= cnt_d;
            ws_q          <= ws_d;
            os_q          <= os_d;
            reject_q      <= reject_d;
        end
    end

endmodule

// File: tb/tb_spmm_tile_sequencer.sv
// Random and directed checks of spmm_tile_sequencer against a
// window-based behavioural model of the host-visible protocol.
module tb_spmm_tile_sequencer;

    localparam int N  = 16;
    localparam int C  = 22;
    localparam int NB = N / 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       rhs_start, lhs_start, lhs_ws, lhs_os, out_start;
    logic       rhs_ready, lhs_ready_ns, lhs_ready_ws;
    logic       lhs_ready_os, lhs_ready_wos, out_ready;
    logic       rhs_wr_en, pe_start, acc_en, out_rd_en;
    logic       out_last, lhs_reject, busy;
    logic [3:0] rhs_row_base, out_row_base;

    int errors = 0;
    int checks = 0;

    spmm_tile_sequencer #(.N(N), .COMPUTE_CYCLES(C)) dut (
        .clock(clock), .reset(reset),
        .rhs_start(rhs_start), .lhs_start(lhs_start),
        .lhs_ws(lhs_ws), .lhs_os(lhs_os), .out_start(out_start),
        .rhs_ready(rhs_ready), .lhs_ready_ns(lhs_ready_ns),
        .lhs_ready_ws(lhs_ready_ws), .lhs_ready_os(lhs_ready_os),
        .lhs_ready_wos(lhs_ready_wos), .out_ready(out_ready),
        .rhs_wr_en(rhs_wr_en), .rhs_row_base(rhs_row_base),
        .pe_start(pe_start), .acc_en(acc_en), .out_rd_en(out_rd_en),
        .out_row_base(out_row_base), .out_last(out_last),
        .lhs_reject(lhs_reject), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // Model: the last accepted op and its accept cycle define fixed windows.
    int mcyc = 0;
    int kind = 0;
    int t0   = 0;
    bit keep = 0, pend = 0, wsq = 0, osq = 0, rej = 0;

    always @(negedge clock) begin
        int d;
        bit bl, bc, bd, free, oacc, racc, lacc, lok;
        mcyc++;
        if (reset) begin
            kind = 0; keep = 0; pend = 0; rej = 0;
        end else begin
            d    = mcyc - t0;
            bl   = (kind == 1) && d >= 1 && d <= NB - 1;
            bc   = (kind == 2) && d >= 1 && d <= C;
            bd   = (kind == 3) && d >= 1 && d <= NB;
            free = !(bl || bc || bd);
            oacc = free && out_start && pend;
            racc = free && rhs_start && !oacc;
            lok  = free && keep && (lhs_os == pend);
            lacc = lhs_start && lok && !oacc && !racc;
            chk("rhs_ready", rhs_ready, free);
            chk("out_ready", out_ready, free && pend);
            chk("lhs_ready_ns", lhs_ready_ns, free && keep && !pend);
            chk("lhs_ready_ws", lhs_ready_ws, free && keep && !pend);
            chk("lhs_ready_os", lhs_ready_os, free && keep && pend);
            chk("lhs_ready_wos", lhs_ready_wos, free && keep && pend);
            chk("busy", busy, !free);
            chk("rhs_wr_en", rhs_wr_en, racc || bl);
            if (racc || bl) chk("rhs_row_base", rhs_row_base, bl ? 4 * d : 0);
            chk("pe_start", pe_start, bc && d == 1);
            chk("acc_en", acc_en, bc && osq);
            chk("out_rd_en", out_rd_en, bd);
            if (bd) chk("out_row_base", out_row_base, 4 * (d - 1));
            chk("out_last", out_last, bd && d == NB);
            chk("lhs_reject", lhs_reject, rej);
            rej = lhs_start && !lacc;
            if (oacc) begin
                kind = 3; t0 = mcyc; pend = 0;
            end else if (racc) begin
                kind = 1; t0 = mcyc; keep = 1;
            end else if (lacc) begin
                kind = 2; t0 = mcyc; wsq = lhs_ws; osq = lhs_os;
                pend = 1; keep = lhs_ws;
            end
        end
    end

    initial begin
        int bc_cnt, pe_cnt;
        reset = 1; rhs_start = 0; lhs_start = 0;
        lhs_ws = 0; lhs_os = 0; out_start = 0;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock); #1;
        chk("lit_reset_rhs_ready", rhs_ready, 1);
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_out_ready", out_ready, 0);
        chk("lit_reset_lhs_ready_ns", lhs_ready_ns, 0);

        @(posedge clock); #1 rhs_start = 1;
        @(negedge clock); #1;
        chk("lit_load_wr0", rhs_wr_en, 1);
        chk("lit_load_base0", rhs_row_base, 0);
        @(posedge clock); #1 rhs_start = 0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clock); #1;
            chk("lit_load_wr", rhs_wr_en, 1);
            chk("lit_load_base", rhs_row_base, 4 * i);
            @(posedge clock); #1;
        end
        lhs_start = 1; lhs_ws = 0; lhs_os = 0;
        @(negedge clock); #1;
        chk("lit_armed_ns", lhs_ready_ns, 1);
        chk("lit_armed_os", lhs_ready_os, 0);
        chk("lit_armed_wr", rhs_wr_en, 0);
        @(posedge clock); #1 lhs_start = 0;
        bc_cnt = 0; pe_cnt = 0;
        for (int i = 0; i < C; i++) begin
            @(negedge clock);
            bc_cnt += int'(busy);
            pe_cnt += int'(pe_start);
            @(posedge clock); #1;
        end
        chk("lit_compute_busy_cycles", bc_cnt, 22);
        chk("lit_compute_pe_pulses", pe_cnt, 1);
        @(negedge clock); #1;
        chk("lit_done_out_ready", out_ready, 1);
        chk("lit_done_ns", lhs_ready_ns, 0);
        chk("lit_done_busy", busy, 0);

        @(posedge clock); #1 out_start = 1;
        @(posedge clock); #1 out_start = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); #1;
            chk("lit_drain_rd", out_rd_en, 1);
            chk("lit_drain_base", out_row_base, 4 * i);
            chk("lit_drain_last", out_last, i == 3);
            @(posedge clock); #1;
        end
        @(negedge clock); #1;
        chk("lit_drained_out_ready", out_ready, 0);

        @(posedge clock); #1 rhs_start = 1;
        @(posedge clock); #1 rhs_start = 0;
        repeat (3) @(posedge clock);
        #1 lhs_start = 1; lhs_ws = 0; lhs_os = 0;
        @(posedge clock); #1 lhs_start = 0;
        repeat (9) @(posedge clock);
        #1 reset = 1;
        @(posedge clock); #1 reset = 0;
        @(negedge clock); #1;
        chk("lit_abort_busy", busy, 0);
        chk("lit_abort_pe", pe_start, 0);
        chk("lit_abort_acc", acc_en, 0);
        chk("lit_abort_rhs_ready", rhs_ready, 1);
        chk("lit_abort_out_ready", out_ready, 0);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clock); #1;
            reset     = ($urandom_range(399) == 0);
            rhs_start = ($urandom_range(9) == 0);
            out_start = ($urandom_range(5) == 0);
            lhs_start = ($urandom_range(2) == 0);
            lhs_ws    = $urandom_range(1) == 1;
            lhs_os    = $urandom_range(1) == 1;
        end
        @(posedge clock); #1;
        reset = 0; rhs_start = 0; lhs_start = 0; out_start = 0;
        repeat (2) @(negedge clock);
        #1 $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
